// File: rtl/stage2_stage3_pipe_if.sv
// -----------------------------------------------------------------------------
// stage2_stage3_pipe_if
// Bundle of the signals between Stage 2 and the Stage 3 pipeline boundary.
//   Stage 2 side : s2_valid/s2_ready handshake, s2_inst, s2_pc, s2_alu_out,
//                  s2_rs2 (raw store data), s2_rs1 (CSR source), flush
//   Stage 3 side : s3_ready in; s3_valid, s3_inst, s3_pc, s3_alu_out,
//                  s3_store_data, s3_store_mask, s3_rs1, s3_misalign out
// master : the environment (Stage 2 producer + Stage 3 consumer)
// slave  : the pipeline boundary block
// -----------------------------------------------------------------------------
interface stage2_stage3_pipe_if;
    logic        s2_valid;
    logic        s2_ready;
    logic [31:0] s2_inst;
    logic [31:0] s2_pc;
    logic [31:0] s2_alu_out;
    logic [31:0] s2_rs2;
    logic [31:0] s2_rs1;
    logic        flush;
    logic        s3_ready;
    logic        s3_valid;
    logic [31:0] s3_inst;
    logic [31:0] s3_pc;
    logic [31:0] s3_alu_out;
    logic [31:0] s3_store_data;
    logic [3:0]  s3_store_mask;
    logic [31:0] s3_rs1;
    logic        s3_misalign;

    modport master (
        output s2_valid, s2_inst, s2_pc, s2_alu_out, s2_rs2, s2_rs1, flush, s3_ready,
        input  s2_ready, s3_valid, s3_inst, s3_pc, s3_alu_out, s3_store_data,
               s3_store_mask, s3_rs1, s3_misalign
    );

    modport slave (
        input  s2_valid, s2_inst, s2_pc, s2_alu_out, s2_rs2, s2_rs1, flush, s3_ready,
        output s2_ready, s3_valid, s3_inst, s3_pc, s3_alu_out, s3_store_data,
               s3_store_mask, s3_rs1, s3_misalign
    );
endinterface

// File: rtl/stage2_stage3_pipe.sv
// -----------------------------------------------------------------------------
// stage2_stage3_pipe
// Stage 2 -> Stage 3 pipeline boundary: a 2-entry skid buffer (head H, skid K)
// with store-lane alignment and misalignment detection done at capture time.
// Ports:
//   clk    : system clock, all state updates on posedge
//   reset  : synchronous active-high reset
//   bus    : stage2_stage3_pipe_if.slave (Stage 2 handshake in, Stage 3 out)
// Every s3_* output and s2_ready come straight from registers.
// -----------------------------------------------------------------------------
module stage2_stage3_pipe #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    reset,
    stage2_stage3_pipe_if.slave     bus
);

    localparam logic [6:0] OP_LOAD  = 7'b000_0011;
    localparam logic [6:0] OP_STORE = 7'b010_0011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] rs1;
        logic        mis;
    } entry_t;

    // Halfword (LH/LHU/SH) with an odd address, or word (LW/SW) not 4-aligned.
    function automatic logic f_misalign(input logic [31:0] inst, input logic [1:0] a);
        logic       is_half;
        logic       is_word;
        logic [2:0] f3;
        f3      = inst[14:12];
        is_half = (f3 == 3'b001) | ((inst[6:0] == OP_LOAD) & (f3 == 3'b101));
        is_word = (f3 == 3'b010);
        if ((inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE)) begin
            return (is_half & a[0]) | (is_word & (a != 2'b00));
        end else begin
            return 1'b0;
        end
    endfunction

    // Byte-write enables; a misaligned store never writes the dcache.
    function automatic logic [3:0] f_store_mask(input logic [31:0] inst, input logic [1:0] a);
        logic [3:0] m;
        if ((inst[6:0] != OP_STORE) || f_misalign(inst, a)) begin
            m = 4'b0000;
        end else begin
            case (inst[14:12])
                3'b000:  m = 4'b0001 << a;
                3'b001:  m = 4'b0011 << {a[1], 1'b0};
                3'b010:  m = 4'b1111;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction

    // Replicate the store operand across all lanes so the mask alone selects bytes.
    function automatic logic [31:0] f_store_data(input logic [31:0] inst, input logic [31:0] rs2);
        logic [31:0] d;
        if (inst[6:0] == OP_STORE) begin
            case (inst[14:12])
                3'b000:  d = {4{rs2[7:0]}};
                3'b001:  d = {2{rs2[15:0]}};
                default: d = rs2;
            endcase
        end else begin
            d = rs2;
        end
        return d;
    endfunction

    // An emptied head presents a NOP with no dcache side effects; other fields stay stale.
    function automatic entry_t f_blank(input entry_t e);
        entry_t b;
        b      = e;
        b.inst = NOP_INST;
        b.mask = 4'b0000;
        b.mis  = 1'b0;
        return b;
    endfunction

    localparam entry_t RESET_ENTRY = '{inst: NOP_INST, pc: 32'h0, alu: 32'h0, data: 32'h0,
                                       mask: 4'h0, rs1: 32'h0, mis: 1'b0};

    entry_t r_h;
    entry_t r_k;
    logic   r_h_valid;
    logic   r_k_valid;

    entry_t w_beat;
    entry_t w_h_next;
    entry_t w_k_next;
    logic   w_h_valid_next;
    logic   w_k_valid_next;
    logic   w_accept;

    // Decorate the incoming Stage 2 beat with its aligned store data, mask and misalign flag.
    always_comb begin
        w_beat.inst = bus.s2_inst;
        w_beat.pc   = bus.s2_pc;
        w_beat.alu  = bus.s2_alu_out;
        w_beat.data = f_store_data(bus.s2_inst, bus.s2_rs2);
        w_beat.mask = f_store_mask(bus.s2_inst, bus.s2_alu_out[1:0]);
        w_beat.rs1  = bus.s2_rs1;
        w_beat.mis  = f_misalign(bus.s2_inst, bus.s2_alu_out[1:0]);
    end

    // Skid-buffer next state: K always drains into H first to preserve arrival order.
    always_comb begin
        w_accept       = bus.s2_valid & ~r_k_valid & ~bus.flush;
        w_h_next       = r_h;
        w_k_next       = r_k;
        w_h_valid_next = r_h_valid;
        w_k_valid_next = r_k_valid;
        if (bus.flush) begin
            w_h_valid_next = 1'b0;
            w_h_next       = f_blank(r_h);
            w_k_valid_next = 1'b0;
        end else if (~r_h_valid | bus.s3_ready) begin
            if (r_k_valid) begin
                w_h_next       = r_k;
                w_h_valid_next = 1'b1;
                if (w_accept) begin
                    w_k_next       = w_beat;
                    w_k_valid_next = 1'b1;
                end else begin
                    w_k_valid_next = 1'b0;
                end
            end else if (w_accept) begin
                w_h_next       = w_beat;
                w_h_valid_next = 1'b1;
                w_k_valid_next = 1'b0;
            end else begin
                w_h_next       = f_blank(r_h);
                w_h_valid_next = 1'b0;
                w_k_valid_next = 1'b0;
            end
        end else begin
            if (w_accept) begin
                w_k_next       = w_beat;
                w_k_valid_next = 1'b1;
            end else begin
                w_k_valid_next = r_k_valid;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h       <= RESET_ENTRY;
            r_k       <= RESET_ENTRY;
            r_h_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else begin
            r_h       <= w_h_next;
            r_k       <= w_k_next;
            r_h_valid <= w_h_valid_next;
            r_k_valid <= w_k_valid_next;
        end
    end

    assign bus.s2_ready      = ~r_k_valid;
    assign bus.s3_valid      = r_h_valid;
    assign bus.s3_inst       = r_h.inst;
    assign bus.s3_pc         = r_h.pc;
    assign bus.s3_alu_out    = r_h.alu;
    assign bus.s3_store_data = r_h.data;
    assign bus.s3_store_mask = r_h.mask;
    assign bus.s3_rs1        = r_h.rs1;
    assign bus.s3_misalign   = r_h.mis;

endmodule
